btb_predictor: RTL
==================

Name: btb_predictor

Overview:
- Branch target buffer and direction predictor feeding the fetch-stage PC register.
- IF side: combinational lookup on the current fetch PC drives predict_taken / predicted_target.
- EX side: resolved branches are compared against the prediction carried down the pipe, producing miss_prediction / correct_address, and the table is trained.
- Direct-mapped, one 2-bit saturating counter per entry.

Parameters:
- ENTRIES, 16: number of BTB entries; power of two, minimum 2.
- IDX_W, $clog2(ENTRIES): index width; index = pc[IDX_W+1:2].
- TAG_W, 30-IDX_W: tag width; tag = pc[31:IDX_W+2].

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  32  fetch PC being looked up
- predict_taken  out  1  BTB hit with counter MSB set
- predicted_target  out  32  stored target on hit-taken; 0 otherwise
- ex_valid  in  1  EX stage holds a real instruction (0 for bubbles/stalls)
- ex_is_branch  in  1  EX instruction is a conditional branch
- ex_pc  in  32  PC of EX instruction
- ex_taken  in  1  resolved branch direction
- ex_target  in  32  resolved branch target
- ex_pred_taken  in  1  predict_taken value carried with this instruction from IF
- ex_pred_target  in  32  predicted_target carried with this instruction from IF
- miss_prediction  out  1  redirect required
- correct_address  out  32  redirect PC; 0 when miss_prediction=0

Behaviour:
- Reset (async): all valid bits cleared, counters = 2'b01 (WNT), tags/targets = 0. Outputs are combinational, so after reset predict_taken=0, predicted_target=0, miss_prediction=0, correct_address=0.
- Lookup (0 cycles, combinational):
  - hit = valid[idx] && tag[idx]==if_pc tag.
  - predict_taken = hit && ctr[idx][1].
- Resolve (combinational, same cycle as EX inputs):
  - actual = ex_taken ? ex_target : ex_pc+4 (32-bit wrap).
  - For a branch: miss when ex_pred_taken != ex_taken, or when both are taken and ex_pred_target != ex_target.
  - For a non-branch with ex_pred_taken=1 (alias): miss, correct_address = ex_pc+4.
  - ex_valid=0: no miss, no update.
- Train (registered at posedge clk when ex_valid):
  - Branch, tag hit at ex idx: counter saturating +1 if taken, -1 if not (11 stays 11, 00 stays 00). If taken, target := ex_target.
  - Branch, tag miss, taken: allocate by overwriting the entry. valid=1, tag, target=ex_target, ctr=2'b10.
  - Branch, tag miss, not taken: no change.
  - Non-branch, tag hit: valid := 0.
- Simultaneous lookup and train at the same index: lookup returns the pre-update contents. The new contents are visible from the next cycle.
- There is no stall input. Fetch stall is handled by the PC holding if_pc; the EX bubble arrives with ex_valid=0.
- Reset asserted mid-operation clears the table immediately. A pending EX update is discarded.

Optional Feature:
- Macro BTB_STATS_EN.
- When defined, adds three 32-bit outputs, all saturating at 32'hFFFF_FFFF and reset to 0:
  - stat_branches: counts ex_valid && ex_is_branch.
  - stat_mispredicts: counts cycles with miss_prediction=1.
  - stat_btb_hits: counts lookup hits where predict_taken=1.
- When undefined, these ports and counters do not exist.

Decomposition:
- Package btb_pkg holds:
  - Counter encodings: CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11.
  - CTR_RESET=CTR_WNT and CTR_ALLOC=CTR_WT.
  - btb_entry_t struct {valid, tag, target, ctr}.
- One sub-module, btb_ctr2: next-state function of the 2-bit saturating counter (inputs ctr, taken; output ctr_next).

Test Plan:
- Reset, if_pc=0x0000_0040 -> predict_taken=0, predicted_target=0; ex_valid=0 -> miss_prediction=0.
- ex_pc=0x40 branch taken, ex_target=0x100, ex_pred_taken=0 -> miss=1, correct_address=0x100. Next cycle, if_pc=0x40 -> predict_taken=1, predicted_target=0x100.
- Same branch not taken with ex_pred_taken=1 -> miss=1, correct_address=0x44. Counter 10->01, so lookup at 0x40 gives predict_taken=0. Three more taken resolves -> ctr=11. One not-taken -> ctr=10, still predicts taken.
- Predicted taken to 0x100, resolved taken to 0x200 -> miss=1, correct_address=0x200. Lookup then returns 0x200.
- Alias: 0x80 maps to the same index as 0x40 (ENTRIES=16). Lookup 0x80 misses. Resolve 0x80 taken to 0x300 -> entry replaced, and lookup 0x40 now misses.
- Non-branch at 0x40 with ex_pred_taken=1 -> miss=1, correct_address=0x44, entry invalidated. Separately, rst_n pulsed during a training cycle -> table cleared and no update applied.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types and counter encodings for the branch target buffer.
package btb_pkg;

   localparam logic [1:0] CTR_SNT = 2'b00;
   localparam logic [1:0] CTR_WNT = 2'b01;
   localparam logic [1:0] CTR_WT  = 2'b10;
   localparam logic [1:0] CTR_ST  = 2'b11;

   localparam logic [1:0] CTR_RESET = CTR_WNT;
   localparam logic [1:0] CTR_ALLOC = CTR_WT;

   // Tags are stored zero-extended to the widest possible tag (ENTRIES >= 2).
   localparam int unsigned MAX_TAG_W = 30;

   typedef struct packed {
      logic                 valid;
      logic [MAX_TAG_W-1:0] tag;
      logic [31:0]          target;
      logic [1:0]           ctr;
   } btb_entry_t;

endpackage

// File: rtl/btb_ctr2.sv
// Next-state function of a 2-bit saturating taken/not-taken counter.
module btb_ctr2
   import btb_pkg::*;
(
   input  logic [1:0] ctr,
   input  logic       taken,
   output logic [1:0] ctr_next
);

   always_comb begin
      ctr_next = ctr;
      if (taken) begin
         if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
      end else begin
         if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
      end
   end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: IF lookup, EX resolve and train.
// Optional statistics counters are enabled by defining BTB_STATS_EN.
module btb_predictor
   import btb_pkg::*;
#(
   parameter int unsigned ENTRIES = 16,
   parameter int unsigned IDX_W   = $clog2(ENTRIES),
   parameter int unsigned TAG_W   = 30 - IDX_W
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] if_pc,
   output logic        predict_taken,
   output logic [31:0] predicted_target,
   input  logic        ex_valid,
   input  logic        ex_is_branch,
   input  logic [31:0] ex_pc,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic        miss_prediction,
   output logic [31:0] correct_address
`ifdef BTB_STATS_EN
   ,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispredicts,
   output logic [31:0] stat_btb_hits
`endif
);

   btb_entry_t table_q [ENTRIES];

   logic [IDX_W-1:0] if_idx, ex_idx;
   logic [TAG_W-1:0] if_tag, ex_tag;
   logic             if_hit, ex_hit;
   btb_entry_t       if_entry, ex_entry, upd_entry;
   logic             upd_en;
   logic [1:0]       ctr_next;
   logic [31:0]      ex_seq_pc, actual_pc;
   logic             unused_pc_bits;

   assign unused_pc_bits = ^{if_pc[1:0]};

   assign if_idx   = if_pc[IDX_W+1:2];
   assign if_tag   = if_pc[31:IDX_W+2];
   assign ex_idx   = ex_pc[IDX_W+1:2];
   assign ex_tag   = ex_pc[31:IDX_W+2];
   assign if_entry = table_q[if_idx];
   assign ex_entry = table_q[ex_idx];

   assign if_hit = if_entry.valid && (if_entry.tag == MAX_TAG_W'(if_tag));
   assign ex_hit = ex_entry.valid && (ex_entry.tag == MAX_TAG_W'(ex_tag));

   // Lookup reads the registered table, so same-cycle training is not forwarded.
   assign predict_taken    = if_hit && if_entry.ctr[1];
   assign predicted_target = predict_taken ? if_entry.target : 32'd0;

   assign ex_seq_pc = ex_pc + 32'd4;
   assign actual_pc = ex_taken ? ex_target : ex_seq_pc;

   always_comb begin
      miss_prediction = 1'b0;
      correct_address = 32'd0;
      if (ex_valid) begin
         if (ex_is_branch) begin
            miss_prediction = (ex_pred_taken != ex_taken) ||
                              (ex_taken && (ex_pred_target != ex_target));
            if (miss_prediction) correct_address = actual_pc;
         end else if (ex_pred_taken) begin
            miss_prediction = 1'b1;
            correct_address = ex_seq_pc;
         end
      end
   end

   btb_ctr2 u_ctr2 (
      .ctr      (ex_entry.ctr),
      .taken    (ex_taken),
      .ctr_next (ctr_next)
   );

   always_comb begin
      upd_en    = 1'b0;
      upd_entry = ex_entry;
      if (ex_valid) begin
         if (ex_is_branch) begin
            if (ex_hit) begin
               upd_en        = 1'b1;
               upd_entry.ctr = ctr_next;
               if (ex_taken) upd_entry.target = ex_target;
            end else if (ex_taken) begin
               upd_en           = 1'b1;
               upd_entry.valid  = 1'b1;
               upd_entry.tag    = MAX_TAG_W'(ex_tag);
               upd_entry.target = ex_target;
               upd_entry.ctr    = CTR_ALLOC;
            end
         end else if (ex_hit) begin
            // A non-branch sitting in the table is a stale alias; drop it.
            upd_en          = 1'b1;
            upd_entry.valid = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
         end
      end else if (upd_en) begin
         table_q[ex_idx] <= upd_entry;
      end
   end

`ifdef BTB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_branches    <= 32'd0;
         stat_mispredicts <= 32'd0;
         stat_btb_hits    <= 32'd0;
      end else begin
         if (ex_valid && ex_is_branch && (stat_branches != '1)) begin
            stat_branches <= stat_branches + 32'd1;
         end
         if (miss_prediction && (stat_mispredicts != '1)) begin
            stat_mispredicts <= stat_mispredicts + 32'd1;
         end
         if (predict_taken && (stat_btb_hits != '1)) begin
            stat_btb_hits <= stat_btb_hits + 32'd1;
         end
      end
   end
`endif

endmodule
